// File: rtl/typing_pkg.sv
// rtl/typing_pkg.sv - shared state encoding and PS/2 prefix bytes for the typing game
package typing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_PLAY       = 3'd3,
    ST_HIT        = 3'd4,
    ST_LEVEL_DONE = 3'd5,
    ST_WIN        = 3'd6,
    ST_LOSE       = 3'd7
  } state_t;

  localparam logic [7:0] SCAN_BREAK = 8'hF0;
  localparam logic [7:0] SCAN_EXT   = 8'hE0;

endpackage

// File: rtl/scancode_filter.sv
// rtl/scancode_filter.sv - drops break sequences and extended prefixes, passes make codes combinationally
module scancode_filter
  import typing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       make_valid,
  output logic [7:0] make_code
);

  logic r_discard;
  logic w_is_break;
  logic w_is_ext;

  assign w_is_break = (key_code == SCAN_BREAK);
  assign w_is_ext   = (key_code == SCAN_EXT);

  // The byte after F0 is the released key; it is swallowed and the flag drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_discard <= 1'b0;
    end else if (key_valid) begin
      if (r_discard) begin
        r_discard <= 1'b0;
      end else if (w_is_break) begin
        r_discard <= 1'b1;
      end
    end
  end

  assign make_valid = key_valid & ~r_discard & ~w_is_break & ~w_is_ext;
  assign make_code  = key_code;

endmodule

// File: rtl/typing_game_ctrl.sv
// rtl/typing_game_ctrl.sv - level/score FSM with settle wait, per-level timer and error limit
module typing_game_ctrl
  import typing_pkg::*;
#(
  parameter int          MAX_LEVELS     = 4,
  parameter int          SETTLE_CYCLES  = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter int          MAX_ERRORS     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic [7:0]  comparison_data,
  input  logic [7:0]  num_char,
  output logic        get_next_character,
  output logic        enable_next_level,
  output logic [2:0]  level,
  output logic [7:0]  char_count,
  output logic [1:0]  error_count,
  output logic [15:0] score,
  output logic [2:0]  game_state
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_settle_cnt;
  logic [31:0] r_timer;
  logic [7:0]  r_char_count;
  logic [1:0]  r_error_count;
  logic [2:0]  r_level;
  logic [15:0] r_score;
  logic        r_enable_next_level;
  logic        r_get_next_character;

  logic        w_make_valid;
  logic [7:0]  w_make_code;
  logic        w_settle_done;
  logic        w_timeout;
  logic        w_key_hit;
  logic        w_key_miss;
  logic [1:0]  w_error_inc;
  logic        w_errors_maxed;
  logic        w_level_full;
  logic        w_last_level;

  scancode_filter u_filter (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .make_valid (w_make_valid),
    .make_code  (w_make_code)
  );

  assign w_settle_done  = (r_settle_cnt == 16'(SETTLE_CYCLES - 1));
  assign w_timeout      = (r_timer == TIMEOUT_CYCLES - 32'd1);
  assign w_key_hit      = w_make_valid && (w_make_code == comparison_data);
  assign w_key_miss     = w_make_valid && (w_make_code != comparison_data);
  assign w_error_inc    = r_error_count + 2'd1;
  assign w_errors_maxed = (w_error_inc == 2'(MAX_ERRORS));
  assign w_level_full   = (r_char_count == num_char);
  assign w_last_level   = (r_level == 3'(MAX_LEVELS - 1));

  // Timeout is tested first so a key landing on the expiring cycle is lost.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) w_next_state = ST_ARM;
      end
      ST_ARM: w_next_state = ST_SETTLE;
      ST_SETTLE: begin
        if (w_settle_done) begin
          if (num_char == 8'd0) w_next_state = ST_LEVEL_DONE;
          else                  w_next_state = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_timeout)                        w_next_state = ST_LOSE;
        else if (w_key_hit)                   w_next_state = ST_HIT;
        else if (w_key_miss && w_errors_maxed) w_next_state = ST_LOSE;
      end
      ST_HIT: begin
        if (w_level_full) w_next_state = ST_LEVEL_DONE;
        else              w_next_state = ST_PLAY;
      end
      ST_LEVEL_DONE: begin
        if (w_last_level) w_next_state = ST_WIN;
        else              w_next_state = ST_ARM;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Pulses are registered from the next state so they coincide with ARM/HIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state              <= ST_IDLE;
      r_settle_cnt         <= 16'd0;
      r_timer              <= 32'd0;
      r_char_count         <= 8'd0;
      r_error_count        <= 2'd0;
      r_level              <= 3'd0;
      r_score              <= 16'd0;
      r_enable_next_level  <= 1'b0;
      r_get_next_character <= 1'b0;
    end else begin
      r_state              <= w_next_state;
      r_enable_next_level  <= (w_next_state == ST_ARM);
      r_get_next_character <= (w_next_state == ST_HIT);
      case (r_state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start) begin
            r_level       <= 3'd0;
            r_score       <= 16'd0;
            r_char_count  <= 8'd0;
            r_error_count <= 2'd0;
          end
        end
        ST_ARM: r_settle_cnt <= 16'd0;
        ST_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 16'd1;
          if (w_settle_done) begin
            r_char_count  <= 8'd0;
            r_error_count <= 2'd0;
            r_timer       <= 32'd0;
          end
        end
        ST_PLAY: begin
          if (!w_timeout) begin
            r_timer <= r_timer + 32'd1;
            if (w_key_hit) begin
              r_char_count <= r_char_count + 8'd1;
              if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
            end else if (w_key_miss) begin
              r_error_count <= w_error_inc;
            end
          end
        end
        ST_LEVEL_DONE: begin
          if (!w_last_level) r_level <= r_level + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign get_next_character = r_get_next_character;
  assign enable_next_level  = r_enable_next_level;
  assign level              = r_level;
  assign char_count         = r_char_count;
  assign error_count        = r_error_count;
  assign score              = r_score;
  assign game_state         = r_state;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// tb/tb_typing_game_ctrl.sv - scoreboard bench with a behavioural sequence parser
module tb_typing_game_ctrl;
  import typing_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic [7:0]  comparison_data;
  logic [7:0]  num_char;
  logic        get_next_character;
  logic        enable_next_level;
  logic [2:0]  level;
  logic [7:0]  char_count;
  logic [1:0]  error_count;
  logic [15:0] score;
  logic [2:0]  game_state;

  int tests = 0;
  int fails = 0;
  int en_count = 0;
  int sc;

  typedef struct packed {
    logic        kind;
    logic [2:0]  lvl;
    logic [7:0]  chars;
    logic [15:0] score;
  } exp_t;
  exp_t sb[$];
  exp_t m_exp;
  exp_t m_act;

  logic [7:0] seq [0:32] = '{
    8'h33, 8'h24, 8'h4B, 8'h4B, 8'h44,
    8'h2C, 8'h43, 8'h1B, 8'h2C, 8'h24, 8'h1B, 8'h2C,
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C};
  int lens [0:3] = '{5, 7, 10, 11};
  int offs [0:3] = '{0, 5, 12, 22};

  typing_game_ctrl #(
    .MAX_LEVELS     (4),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (32'd100),
    .MAX_ERRORS     (3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .key_valid          (key_valid),
    .key_code           (key_code),
    .comparison_data    (comparison_data),
    .num_char           (num_char),
    .get_next_character (get_next_character),
    .enable_next_level  (enable_next_level),
    .level              (level),
    .char_count         (char_count),
    .error_count        (error_count),
    .score              (score),
    .game_state         (game_state)
  );

  always #5 clk = ~clk;

  int p_lvl, p_idx, p_loads;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p_lvl <= 0; p_idx <= 0; p_loads <= 0;
    end else if (enable_next_level) begin
      p_lvl   <= (p_loads < 4) ? p_loads : 3;
      p_idx   <= 0;
      p_loads <= p_loads + 1;
    end else if (get_next_character) begin
      p_idx <= p_idx + 1;
    end
  end
  assign num_char        = 8'(lens[p_lvl]);
  assign comparison_data = (p_idx < lens[p_lvl]) ? seq[offs[p_lvl] + p_idx] : 8'h00;

  always @(negedge clk) begin
    if (!reset && (enable_next_level || get_next_character)) begin
      tests++;
      if (enable_next_level) en_count++;
      m_act.kind  = get_next_character;
      m_act.lvl   = level;
      m_act.chars = char_count;
      m_act.score = score;
      if (enable_next_level && get_next_character) begin
        fails++;
        $display("FAIL pulse_overlap: both pulses high at %0t", $time);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got kind=%0d lvl=%0d chars=%0d score=%0d, none expected",
                 m_act.kind, m_act.lvl, m_act.chars, m_act.score);
      end else begin
        m_exp = sb.pop_front();
        if (m_act !== m_exp) begin
          fails++;
          $display("FAIL pulse_record: got kind=%0d lvl=%0d chars=%0d score=%0d, expected kind=%0d lvl=%0d chars=%0d score=%0d",
                   m_act.kind, m_act.lvl, m_act.chars, m_act.score,
                   m_exp.kind, m_exp.lvl, m_exp.chars, m_exp.score);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic k, input logic [2:0] l, input logic [7:0] c, input logic [15:0] s);
    exp_t e;
    e.kind = k; e.lvl = l; e.chars = c; e.score = s;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (game_state !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(game_state), 32'(s));
  endtask

  task automatic send_key(input logic [7:0] b);
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = b;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    push(1'b0, 3'd0, 8'd0, 16'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_state", 32'(game_state), 32'(ST_IDLE));
    check("rst_pulses", 32'({enable_next_level, get_next_character}), 32'd0);
    check("rst_counters", 32'({level, char_count, error_count, score}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Full game: HELLO then three more levels to WIN.
    do_start();
    sc = 0;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < lens[l]; i++) begin
        wait_state(ST_PLAY, "play");
        sc++;
        push(1'b1, 3'(l), 8'(i + 1), 16'(sc));
        if (i == lens[l] - 1 && l < 3) push(1'b0, 3'(l + 1), 8'(lens[l]), 16'(sc));
        send_key(seq[offs[l] + i]);
      end
      if (l == 0) begin
        wait_state(ST_ARM, "arm_lvl1");
        check("hello_level", 32'(level), 32'd1);
        check("hello_chars", 32'(char_count), 32'd5);
      end
    end
    wait_state(ST_WIN, "win");
    check("win_score", 32'(score), 32'd33);
    check("win_level", 32'(level), 32'd3);
    check("win_chars", 32'(char_count), 32'd11);
    check("win_enables", 32'(en_count), 32'd4);
    repeat (5) @(posedge clk); #1;
    check("win_hold", 32'({game_state, score}), 32'({3'(ST_WIN), 16'd33}));

    // Break filter and extended prefix.
    do_reset();
    do_start();
    wait_state(ST_PLAY, "brk_play");
    send_key(8'hF0);
    send_key(8'h33);
    check("brk_dropped", 32'(char_count), 32'd0);
    send_key(8'hE0);
    check("ext_dropped", 32'(error_count), 32'd0);
    push(1'b1, 3'd0, 8'd1, 16'd1);
    send_key(8'h33);
    wait_state(ST_PLAY, "brk_play2");
    check("brk_accept", 32'(char_count), 32'd1);

    // Three wrong keys lose the game.
    do_reset();
    do_start();
    wait_state(ST_PLAY, "err_play");
    send_key(8'h1C);
    send_key(8'h1C);
    check("err_two", 32'({game_state, error_count}), 32'({3'(ST_PLAY), 2'd2}));
    send_key(8'h1C);
    check("err_lose", 32'(game_state), 32'(ST_LOSE));
    check("err_count", 32'(error_count), 32'd3);

    // Timeout on PLAY cycle 100 beats a correct key in the same cycle.
    do_reset();
    do_start();
    wait_state(ST_PLAY, "to_play");
    repeat (98) @(posedge clk);
    @(posedge clk); #1;
    check("to_cycle100_play", 32'(game_state), 32'(ST_PLAY));
    key_valid = 1'b1; key_code = 8'h33;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("to_lose", 32'(game_state), 32'(ST_LOSE));
    check("to_key_ignored", 32'({char_count, score}), 32'd0);

    // Reset during HIT aborts with no pulse on release.
    do_reset();
    do_start();
    wait_state(ST_PLAY, "rh_play");
    send_key(8'h33);
    check("rh_in_hit", 32'(game_state), 32'(ST_HIT));
    reset = 1'b1;
    #1;
    check("rh_state", 32'(game_state), 32'(ST_IDLE));
    check("rh_pulses", 32'({enable_next_level, get_next_character}), 32'd0);
    check("rh_counters", 32'({level, char_count, error_count, score}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rh_idle_after", 32'(game_state), 32'(ST_IDLE));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
